// File: rtl/be_stream_to_le_word.sv
// Big-endian byte stream to little-endian word reassembler.
// Bytes arrive MSB first and are packed into right-aligned DATA_W words with a byte count.
//
// state   | meaning
// COLLECT | accepting bytes into acc; a closing byte goes straight to the output register when it is free
// PENDING | a closed word waits in acc/cnt for the output register; byte input is stalled
module be_stream_to_le_word #(
  parameter int DATA_W = 32,
  parameter int BYTE   = 8,
  localparam int NBYTES = DATA_W / BYTE,
  localparam int CNT_W  = $clog2(NBYTES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE-1:0]   be_byte_i,
  input  logic              be_valid_i,
  input  logic              be_last_i,
  output logic              be_ready_o,
  output logic [DATA_W-1:0] le_data_o,
  output logic [CNT_W-1:0]  le_bytes_o,
  output logic              le_valid_o,
  input  logic              le_ready_i
);

  if ((DATA_W % BYTE) != 0 || NBYTES < 2) begin : g_param_check
    $error("be_stream_to_le_word: DATA_W must be a multiple of BYTE with at least two lanes");
  end

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_free;
  logic              byte_hs;
  logic              closing;
  logic [DATA_W-1:0] shifted;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0]  load_bytes;

  // Ready depends only on registered state (and reset), never on the incoming byte.
  assign be_ready_o = (state_q == COLLECT) && !reset;
  assign out_free   = !le_valid_o || le_ready_i;
  assign byte_hs    = be_valid_i && be_ready_o;
  assign shifted    = {acc_q[DATA_W-BYTE-1:0], be_byte_i};
  assign closing    = be_last_i || (cnt_q == CNT_W'(NBYTES - 1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    load_data  = '0;
    load_bytes = '0;

    unique case (state_q)
      COLLECT: begin
        if (byte_hs) begin
          if (!closing) begin
            acc_d = shifted;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (out_free) begin
            load       = 1'b1;
            load_data  = shifted;
            load_bytes = cnt_q + CNT_W'(1);
            acc_d      = '0;
            cnt_d      = '0;
          end else begin
            // In PENDING, cnt holds the final byte count rather than an index.
            acc_d   = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (out_free) begin
          load       = 1'b1;
          load_data  = acc_q;
          load_bytes = cnt_q;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      le_valid_o <= 1'b0;
      le_data_o  <= '0;
      le_bytes_o <= '0;
    end else if (load) begin
      le_valid_o <= 1'b1;
      le_data_o  <= load_data;
      le_bytes_o <= load_bytes;
    end else if (le_valid_o && le_ready_i) begin
      le_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/be_stream_to_le_word.md
Name: be_stream_to_le_word

Overview:
- Receive side of the endianness path: accepts a big-endian byte stream (most significant byte first), one byte per handshake.
- Reassembles the bytes into native little-endian DATA_W words.
- Presents each word on a valid/ready output with a byte count, so short final words are reported.
- Sits between a byte-serial link/parser and word-wide internal datapaths.

Parameters:
- DATA_W, 32, output word width in bits; must be an integer multiple of BYTE.
- BYTE, 8, lane width in bits.
- Derived (not overridable): NBYTES = DATA_W/BYTE (must be >= 2); CNT_W = $clog2(NBYTES)+1.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- be_byte_i  input  BYTE  stream byte; the first byte of a word is the most significant.
- be_valid_i  input  1  be_byte_i valid.
- be_last_i  input  1  qualifies with be_valid_i; closes the current word early.
- be_ready_o  output  1  block can accept a byte this cycle.
- le_data_o  [output]  DATA_W  assembled word, native numeric value.
- le_bytes_o  output  CNT_W  number of valid bytes in le_data_o, range 1..NBYTES.
- le_valid_o  output  1  le_data_o and le_bytes_o valid.
- le_ready_i  input  1  downstream accepts the word.

Behaviour:
- Byte handshake = be_valid_i && be_ready_o at a rising edge. Word handshake = le_valid_o && le_ready_i.
- Internal state:
  - accumulator acc[DATA_W-1:0].
  - byte counter cnt (0..NBYTES-1).
  - output register holding le_data_o, le_bytes_o and le_valid_o.
  - FSM with states COLLECT and PENDING.
- Reset (synchronous, takes priority over everything):
  - state=COLLECT, acc=0, cnt=0.
  - le_valid_o=0, le_data_o=0, le_bytes_o=0.
  - be_ready_o=0 while reset is high.
  - Any partial word or pending word is discarded.
- be_ready_o is a registered-state decode only, never combinational from be_valid_i or be_last_i:
  - COLLECT: be_ready_o=1.
  - PENDING: be_ready_o=0.
- "Output free" = !le_valid_o || le_ready_i (combinational).
- COLLECT, byte handshake:
  - Shift: acc <= {acc[DATA_W-BYTE-1:0], be_byte_i}.
  - A word closes when be_last_i=1 or cnt==NBYTES-1.
  - Word not closing: cnt <= cnt+1.
  - Word closing with output free:
    - Load le_data_o with the shifted value, right-aligned and zero-extended. Bytes b0..b(k-1) give le_data_o = {zeros, b0, ..., b(k-1)}.
    - Load le_bytes_o = cnt+1 and set le_valid_o=1.
    - Clear acc and cnt; stay in COLLECT.
  - Word closing with output busy: store the shifted value in acc and the count; go to PENDING.
- PENDING:
  - No bytes are accepted.
  - On the first edge where the output is free: load the output register from acc and the stored count, set le_valid_o=1, clear acc and cnt, return to COLLECT.
- Output register:
  - On a word handshake with no new load, le_valid_o <= 0.
  - Handshake and new load in the same edge: the new word replaces the old one and le_valid_o stays 1.
  - While le_valid_o && !le_ready_i, le_data_o and le_bytes_o hold stable.
- Latency:
  - le_valid_o rises on the edge of the closing byte handshake, i.e. it is visible the next cycle.
  - If the output is busy, the word is delayed until the output frees, +1 edge.
- Throughput: 1 byte/cycle sustained with le_ready_i=1; one word every NBYTES cycles; be_ready_o never drops in that case.
- Idle cycles (be_valid_i=0) inside a word are allowed; acc and cnt hold.
- be_last_i is ignored when be_valid_i=0.
- be_last_i on the NBYTES-th byte is identical to a full word (le_bytes_o=NBYTES).
- No overflow is possible: a word always closes at NBYTES.

Test Plan:
- Reset, then bytes 0x12,0x34,0x56,0x78 on consecutive cycles, be_last_i on the 4th, le_ready_i=1 -> le_data_o=0x12345678, le_bytes_o=4, le_valid_o high exactly one cycle, starting the cycle after the 4th handshake.
- Short words: 0xAB,0xCD with last on 0xCD -> 0x0000ABCD, bytes=2. Then 0xEE with last -> 0x000000EE, bytes=1. Then 0x11,0x22,0x33 with last -> 0x00112233, bytes=3.
- Gapless 8 bytes 0x00..0x07, no last, le_ready_i=1 -> 0x00010203 then 0x04050607, be_ready_o constant 1, 4 cycles between the two le_valid_o pulses.
- Backpressure: le_ready_i=0; send 0x01020304 then 0x05060708 -> first word held stable; after the 8th byte handshake be_ready_o=0 (PENDING). Raise le_ready_i -> 0x01020304 is consumed, 0x05060708 appears the next cycle, be_ready_o returns to 1, no byte lost.
- Reset mid-word: 0xAA,0xBB, then reset for 1 cycle, then 0x11,0x22,0x33,0x44 -> only 0x11223344 is produced. Reset asserted while le_valid_o=1 -> le_valid_o=0 on the next cycle.
- Random be_valid_i gaps and random le_ready_i, 1000 words of random length 1..4, compared against a reference model -> no loss, duplication or reorder; le_data_o and le_bytes_o stable while stalled.
